// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - steps an 8-note melody ROM for REPEAT passes
// and drives the square-wave tone generator's on/sound inputs.
module melody_sequencer #(
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 1_000_000,
  parameter int REPEAT      = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  output logic        on,
  output logic [19:0] sound,
  output logic        busy,
  output logic        done,
  output logic [2:0]  note_idx
);

  localparam int MAXD = (4 * BEAT_CYCLES > GAP_CYCLES) ? 4 * BEAT_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXD + 1);
  localparam logic [CW-1:0] BEAT     = CW'(BEAT_CYCLES);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [3:0]    LAST_PASS = 4'(REPEAT - 1);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    pass;
  logic [CW-1:0] play_last;
  logic [2:0]    next_idx;

  function automatic logic [19:0] rom_sound(input logic [2:0] i);
    case (i)
      3'd0:    return 20'd95555;
      3'd1:    return 20'd85130;
      3'd2:    return 20'd75841;
      3'd3:    return 20'd95555;
      3'd4:    return 20'd75841;
      3'd5:    return 20'd0;
      3'd6:    return 20'd63775;
      default: return 20'd47777;
    endcase
  endfunction

  function automatic logic [2:0] rom_beats(input logic [2:0] i);
    case (i)
      3'd4, 3'd6: return 3'd2;
      3'd7:       return 3'd4;
      default:    return 3'd1;
    endcase
  endfunction

  assign play_last = CW'(rom_beats(note_idx)) * BEAT - CW'(1);
  assign next_idx  = note_idx + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      pass     <= '0;
      on       <= 1'b0;
      sound    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      note_idx <= '0;
    end else begin
      done <= 1'b0;
      if (stop && state != IDLE) begin
        state    <= IDLE;
        cnt      <= '0;
        pass     <= '0;
        on       <= 1'b0;
        sound    <= '0;
        busy     <= 1'b0;
        note_idx <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !stop) begin
              state    <= PLAY;
              cnt      <= '0;
              pass     <= '0;
              note_idx <= '0;
              sound    <= rom_sound(3'd0);
              on       <= |rom_sound(3'd0);
              busy     <= 1'b1;
            end
          end
          PLAY: begin
            if (cnt == play_last) begin
              state <= GAP;
              on    <= 1'b0;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          GAP: begin
            if (cnt == GAP_LAST) begin
              cnt <= '0;
              // Next note loads on the same edge the gap ends: no bubble cycle.
              if (note_idx != 3'd7) begin
                state    <= PLAY;
                note_idx <= next_idx;
                sound    <= rom_sound(next_idx);
                on       <= |rom_sound(next_idx);
              end else if (pass != LAST_PASS) begin
                state    <= PLAY;
                pass     <= pass + 4'd1;
                note_idx <= '0;
                sound    <= rom_sound(3'd0);
                on       <= |rom_sound(3'd0);
              end else begin
                state    <= IDLE;
                pass     <= '0;
                done     <= 1'b1;
                busy     <= 1'b0;
                sound    <= '0;
                note_idx <= '0;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// tb/tb_melody_sequencer.sv - directed self-checking bench for melody_sequencer
// with BEAT_CYCLES=4, GAP_CYCLES=2, REPEAT=2.
module tb_melody_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        on;
  logic [19:0] sound;
  logic        busy;
  logic        done;
  logic [2:0]  note_idx;

  int errors = 0;
  int checks = 0;

  int exp_sound [8] = '{95555, 85130, 75841, 95555, 75841, 0, 63775, 47777};
  int exp_beats [8] = '{1, 1, 1, 1, 2, 1, 2, 4};

  melody_sequencer #(.BEAT_CYCLES(4), .GAP_CYCLES(2), .REPEAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .on(on),
    .sound(sound), .busy(busy), .done(done), .note_idx(note_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge of the first PLAY cycle of note 0.
  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".on"}, on, 0);
    check({tag, ".sound"}, sound, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".note_idx"}, note_idx, 0);
  endtask

  initial begin
    int busy_cnt;
    int wraps;
    int prev_idx;
    int done_seen;

    // Reset state
    cyc();
    check_idle("reset");
    check("reset.done", done, 0);
    rst_n = 1'b1;
    repeat (3) cyc();
    check_idle("idle_after_reset");

    // 1. Reset mid-note during note 2
    pulse_start();
    repeat (13) cyc();
    check("t1.in_note2", note_idx, 2);
    check("t1.on_before", on, 1);
    rst_n = 1'b0;
    #1;
    check_idle("t1.async_reset");
    cyc();
    rst_n = 1'b1;
    repeat (5) cyc();
    check_idle("t1.stays_idle");

    // 2+3. Full run, per-cycle note timing
    busy_cnt = 0;
    wraps = 0;
    prev_idx = 0;
    pulse_start();
    for (int p = 0; p < 2; p++) begin
      for (int n = 0; n < 8; n++) begin
        for (int c = 0; c < exp_beats[n] * 4; c++) begin
          check($sformatf("t2.p%0d.n%0d.c%0d.on", p, n, c), on, (exp_sound[n] != 0) ? 1 : 0);
          check($sformatf("t2.p%0d.n%0d.c%0d.sound", p, n, c), sound, exp_sound[n]);
          check($sformatf("t2.p%0d.n%0d.c%0d.idx", p, n, c), note_idx, n);
          if (busy) busy_cnt++;
          if (prev_idx == 7 && note_idx == 0) wraps++;
          prev_idx = note_idx;
          cyc();
        end
        for (int g = 0; g < 2; g++) begin
          check($sformatf("t2.p%0d.n%0d.g%0d.on", p, n, g), on, 0);
          check($sformatf("t2.p%0d.n%0d.g%0d.sound", p, n, g), sound, exp_sound[n]);
          check($sformatf("t2.p%0d.n%0d.g%0d.done", p, n, g), done, 0);
          if (busy) busy_cnt++;
          cyc();
        end
      end
    end
    check("t3.busy_cycles", busy_cnt, 136);
    check("t3.wraps", wraps, 1);
    check("t3.done_pulse", done, 1);
    check_idle("t3.end");
    cyc();
    check("t3.done_cleared", done, 0);

    // 4. Stop during GAP of note 3
    pulse_start();
    repeat (22) cyc();
    check("t4.gap_idx", note_idx, 3);
    check("t4.gap_on", on, 0);
    check("t4.gap_busy", busy, 1);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check_idle("t4.stopped");
    done_seen = 0;
    for (int i = 0; i < 160; i++) begin
      if (done) done_seen++;
      cyc();
    end
    check("t4.no_done", done_seen, 0);
    check_idle("t4.still_idle");

    // 5. start+stop together, then start while busy
    start = 1'b1;
    stop = 1'b1;
    cyc();
    start = 1'b0;
    stop = 1'b0;
    check_idle("t5.both");
    repeat (3) cyc();
    check_idle("t5.both_later");
    pulse_start();
    repeat (7) cyc();
    check("t5.note1_idx", note_idx, 1);
    pulse_start();
    check("t5.c3_on", on, 1);
    check("t5.c3_idx", note_idx, 1);
    cyc();
    check("t5.c4_on", on, 1);
    cyc();
    check("t5.g0_on", on, 0);
    cyc();
    check("t5.g1_on", on, 0);
    check("t5.g1_idx", note_idx, 1);
    cyc();
    check("t5.n2_on", on, 1);
    check("t5.n2_idx", note_idx, 2);
    check("t5.n2_sound", sound, 75841);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check_idle("t5.abort");

    // 6. start on the done cycle restarts playback
    pulse_start();
    repeat (136) cyc();
    check("t6.done", done, 1);
    check("t6.busy_low", busy, 0);
    pulse_start();
    check("t6.busy", busy, 1);
    check("t6.idx", note_idx, 0);
    check("t6.sound", sound, 95555);
    check("t6.on", on, 1);
    check("t6.done_cleared", done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
